// File: rtl/seg_pkg.sv
// seg_pkg: glyph codes, active-low segment patterns and FSM states for seg_frame_capture
package seg_pkg;
    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] code_t;
    typedef enum logic {IDLE, PEND} state_t;
    localparam code_t CODE_0 = 5'd0;
    localparam code_t CODE_1 = 5'd1;
    localparam code_t CODE_2 = 5'd2;
    localparam code_t CODE_3 = 5'd3;
    localparam code_t CODE_4 = 5'd4;
    localparam code_t CODE_5 = 5'd5;
    localparam code_t CODE_6 = 5'd6;
    localparam code_t CODE_7 = 5'd7;
    localparam code_t CODE_8 = 5'd8;
    localparam code_t CODE_9 = 5'd9;
    localparam code_t CODE_E = 5'd10;
    localparam code_t CODE_A = 5'd11;
    localparam code_t CODE_Y = 5'd12;
    localparam code_t CODE_H = 5'd13;
    localparam code_t CODE_R = 5'd14;
    localparam code_t CODE_D = 5'd15;
    localparam code_t CODE_L = 5'd16;
    localparam code_t CODE_BLANK = 5'd30;
    localparam code_t CODE_INVALID = 5'd31;
    // segment order {g,f,e,d,c,b,a}, low = lit
    localparam logic [6:0] G_0 = 7'b1000000;
    localparam logic [6:0] G_1 = 7'b1111001;
    localparam logic [6:0] G_2 = 7'b0100100;
    localparam logic [6:0] G_3 = 7'b0110000;
    localparam logic [6:0] G_4 = 7'b0011001;
    localparam logic [6:0] G_5 = 7'b0010010;
    localparam logic [6:0] G_6 = 7'b0000010;
    localparam logic [6:0] G_7 = 7'b1111000;
    localparam logic [6:0] G_8 = 7'b0000000;
    localparam logic [6:0] G_9 = 7'b0010000;
    localparam logic [6:0] G_E = 7'b0000110;
    localparam logic [6:0] G_A = 7'b0001000;
    localparam logic [6:0] G_Y = 7'b0010001;
    localparam logic [6:0] G_H = 7'b0001001;
    localparam logic [6:0] G_R = 7'b0101111;
    localparam logic [6:0] G_D = 7'b0100001;
    localparam logic [6:0] G_L = 7'b1000111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: active-low segment pattern to glyph code; letters only with SEG_LETTER_DECODE_EN
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output code_t      code,
    output logic       invalid
);
    // S shares the 5 pattern, so it always decodes as 5
    always_comb begin
        code = CODE_INVALID;
        case (seg_n)
            G_0: code = CODE_0;
            G_1: code = CODE_1;
            G_2: code = CODE_2;
            G_3: code = CODE_3;
            G_4: code = CODE_4;
            G_5: code = CODE_5;
            G_6: code = CODE_6;
            G_7: code = CODE_7;
            G_8: code = CODE_8;
            G_9: code = CODE_9;
            G_BLANK: code = CODE_BLANK;
`ifdef SEG_LETTER_DECODE_EN
            G_E: code = CODE_E;
            G_A: code = CODE_A;
            G_Y: code = CODE_Y;
            G_H: code = CODE_H;
            G_R: code = CODE_R;
            G_D: code = CODE_D;
            G_L: code = CODE_L;
`endif
            default: code = CODE_INVALID;
        endcase
    end
    assign invalid = code == CODE_INVALID;
endmodule

// File: rtl/seg_frame_capture.sv
// seg_frame_capture: debounced 7-seg bus readback into glyph frames on valid/ready.
// Letter glyphs decode only when SEG_LETTER_DECODE_EN is defined.
module seg_frame_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_en,
    input  logic [6:0]                   seg_n,
    input  logic [NUM_DIGITS-1:0]        dig_sel,
    output logic [CODE_W*NUM_DIGITS-1:0] frame_code,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         glyph_error,
    output logic                         overflow
);
    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);
    code_t code;
    logic invalid, take, eligible, cand_new, load, accept, ovf_set, rep_valid;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] last, reported;
    logic [NUM_DIGITS-1:0][3:0] cnt;
    state_t state, state_nx;
    seg_glyph_decode u_dec (.seg_n(seg_n), .code(code), .invalid(invalid));
    assign take = sample_en && dig_sel != '0 && (dig_sel & (dig_sel - 1'b1)) == '0;
    always_comb begin
        eligible = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            eligible = eligible && cnt[i] == STABLE && last[i] != CODE_INVALID;
    end
    assign cand_new    = !rep_valid || last != reported;
    assign frame_valid = state == PEND;
    always_comb begin
        load     = state == IDLE && eligible && cand_new;
        accept   = state == PEND && frame_ready;
        ovf_set  = state == PEND && eligible && cand_new && last != frame_code;
        state_nx = state == IDLE ? (load ? PEND : IDLE) : (accept ? IDLE : PEND);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_code  <= '0;
            glyph_error <= 1'b0;
            overflow    <= 1'b0;
            rep_valid   <= 1'b0;
            reported    <= '0;
            cnt         <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) last[i] <= CODE_BLANK;
        end else begin
            state       <= state_nx;
            glyph_error <= take && invalid;
            overflow    <= overflow || ovf_set;
            if (load) frame_code <= last;
            if (accept) begin
                reported  <= frame_code;
                rep_valid <= 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++)
                if (take && dig_sel[i]) begin
                    if (code == last[i]) begin
                        cnt[i] <= cnt[i] == STABLE ? cnt[i] : cnt[i] + 4'd1;
                    end else begin
                        last[i] <= code;
                        cnt[i]  <= 4'd1;
                    end
                end
        end
    end
endmodule

// File: tb/tb_seg_frame_capture.sv
// tb_seg_frame_capture: directed vectors with hand-computed frames, errors and overflow
module tb_seg_frame_capture;
    logic clk = 0, reset = 1, sample_en = 0, frame_ready = 0;
    logic [6:0] seg_n = 7'b1111111;
    logic [3:0] dig_sel = 4'b0000;
    logic [19:0] frame_code;
    logic frame_valid, glyph_error, overflow;
    int passed = 0, total = 0, hs_cnt = 0;
    localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
    localparam logic [6:0] SE = 7'b0000110, SA = 7'b0001000, SY = 7'b0010001;
    seg_frame_capture #(.NUM_DIGITS(4), .STABLE_COUNT(3)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .seg_n(seg_n), .dig_sel(dig_sel),
        .frame_code(frame_code), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .glyph_error(glyph_error), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (!reset && frame_valid && frame_ready) hs_cnt <= hs_cnt + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic samp(input logic [3:0] sel, input logic [6:0] s);
        sample_en = 1; dig_sel = sel; seg_n = s;
        @(negedge clk);
        sample_en = 0;
    endtask
    task automatic scan(input logic [6:0] s3, s2, s1, s0);
        samp(4'b1000, s3); samp(4'b0100, s2); samp(4'b0010, s1); samp(4'b0001, s0);
    endtask
    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        check("rst_code", 32'(frame_code), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_gerr", 32'(glyph_error), 0);
        check("rst_ovf", 32'(overflow), 0);
        // first frame with ready held high: one-cycle valid, two cycles after last sample
        frame_ready = 1;
        scan(S1, S2, S3, S4); scan(S1, S2, S3, S4); scan(S1, S2, S3, S4);
        check("f1_t1", 32'(frame_valid), 0);
        @(negedge clk);
        check("f1_t2", 32'(frame_valid), 1);
        check("f1_code", 32'(frame_code), 32'h08864);
        @(negedge clk);
        check("f1_t3", 32'(frame_valid), 0);
        check("f1_hs", hs_cnt, 1);
        repeat (3) scan(S1, S2, S3, S4);
        repeat (3) @(negedge clk);
        check("repeat_hs", hs_cnt, 1);
        check("repeat_valid", 32'(frame_valid), 0);
        // digit 0 flickers 6,5,6 then settles on 6
        samp(4'b0001, S6); samp(4'b0001, S5); samp(4'b0001, S6); samp(4'b0001, S6);
        repeat (2) @(negedge clk);
        check("flick_hs", hs_cnt, 1);
        samp(4'b0001, S6);
        check("flick_t1", 32'(frame_valid), 0);
        @(negedge clk);
        check("flick_t2", 32'(frame_valid), 1);
        check("flick_code", 32'(frame_code), 32'h08866);
        @(negedge clk);
        check("flick_hs2", hs_cnt, 2);
        // unrecognised glyph on digit 2
        samp(4'b0100, 7'b1010101);
        check("gerr_hi", 32'(glyph_error), 1);
        @(negedge clk);
        check("gerr_lo", 32'(glyph_error), 0);
        repeat (3) scan(S1, 7'b1010101, S3, S4);
        repeat (3) @(negedge clk);
        check("inv_hs", hs_cnt, 2);
        check("inv_valid", 32'(frame_valid), 0);
        // non-one-hot select is ignored, even with a bad pattern
        samp(4'b0011, 7'b1010101);
        check("multi_sel_gerr", 32'(glyph_error), 0);
        samp(4'b0000, 7'b1010101);
        check("no_sel_gerr", 32'(glyph_error), 0);
        // overflow while a frame is pending
        do_reset();
        frame_ready = 0;
        repeat (3) scan(S1, S2, S3, S4);
        repeat (2) @(negedge clk);
        check("pend_valid", 32'(frame_valid), 1);
        check("pend_code", 32'(frame_code), 32'h08864);
        check("pend_ovf0", 32'(overflow), 0);
        repeat (3) samp(4'b0001, S5);
        repeat (2) @(negedge clk);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_code", 32'(frame_code), 32'h08864);
        check("ovf_valid", 32'(frame_valid), 1);
        frame_ready = 1;
        @(negedge clk);
        check("ovf_acc_hs", hs_cnt, 3);
        check("ovf_gap", 32'(frame_valid), 0);
        @(negedge clk);
        check("ovf_next_valid", 32'(frame_valid), 1);
        check("ovf_next_code", 32'(frame_code), 32'h08865);
        @(negedge clk);
        check("ovf_next_hs", hs_cnt, 4);
        check("ovf_sticky", 32'(overflow), 1);
        // letters
        do_reset();
        check("rst2_ovf", 32'(overflow), 0);
        frame_ready = 0;
        samp(4'b1000, SE);
`ifdef SEG_LETTER_DECODE_EN
        check("easy_gerr", 32'(glyph_error), 0);
`else
        check("easy_gerr", 32'(glyph_error), 1);
`endif
        samp(4'b0100, SA); samp(4'b0010, S5); samp(4'b0001, SY);
        scan(SE, SA, S5, SY); scan(SE, SA, S5, SY);
        repeat (2) @(negedge clk);
`ifdef SEG_LETTER_DECODE_EN
        check("easy_valid", 32'(frame_valid), 1);
        check("easy_code", 32'(frame_code), 32'h52CAC);
`else
        check("easy_valid", 32'(frame_valid), 0);
        check("easy_code", 32'(frame_code), 0);
`endif
        // reset mid-operation drops a pending frame
        repeat (3) scan(S1, S2, S3, S4);
        repeat (2) @(negedge clk);
        check("mid_pend", 32'(frame_valid), 1);
        frame_ready = 1;
        reset = 1;
        @(negedge clk);
        reset = 0;
        frame_ready = 0;
        check("mid_valid", 32'(frame_valid), 0);
        check("mid_code", 32'(frame_code), 0);
        check("mid_hs", hs_cnt, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
